lomo_frame_receiver: RTL and testbench
======================================

LOMO_FRAME_RECEIVER -- requirements
Module: lomo_frame_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4096: clk cycles without a CLK falling edge before lock is dropped.
REQ-002 SHALL have parameter ERR_CNT_W, default 8: width of the saturating error counter.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port MK, input, 1, frame marker from the serial link, asynchronous to clk.
REQ-006 SHALL have port CLK, input, 1, serial bit clock, asynchronous to clk; DAT changes on its rising edge.
REQ-007 SHALL have port DAT, input, 1, serial data, MSB first, 16-bit words.
REQ-008 SHALL have port word_data, output, 16, last fully received word.
REQ-009 SHALL have port word_idx, output, 5, index 0..19 of word_data within its string.
REQ-010 SHALL have port str_idx, output, 6, index 0..63 of the string holding word_data.
REQ-011 SHALL have port word_valid, output, 1, one-cycle strobe: word_data, word_idx and str_idx are new.
REQ-012 SHALL have port frame_start, output, 1, one-cycle strobe coincident with word_valid for word 0 of string 0.
REQ-013 SHALL have port frm_num, output, 9, frame number taken from bits [15:7] of word 0, string 0.
REQ-014 SHALL have port locked, output, 1, high while aligned to the frame structure.
REQ-015 SHALL have port err_marker, output, 1, one-cycle strobe on a misplaced MK.
REQ-016 SHALL have port err_tag, output, 1, one-cycle strobe on a wrong tag bit.
REQ-017 SHALL have port err_cnt, output, ERR_CNT_W, count of errors, saturating.

Function
REQ-018 CLK, MK and DAT SHALL each pass through a 3-flop synchronizer; a CLK falling edge is synchronized CLK stage 2 low and stage 3 high.
REQ-019 On each detected CLK falling edge, the stage-2 values of DAT and MK SHALL be sampled together as one bit.
REQ-020 Frame geometry: 16 bits/word, 20 words/string, 64 strings/frame, 20480 bits/frame.
REQ-021 State machine: HUNT, LOCKED.
REQ-022 In HUNT, bits with MK=0 SHALL be discarded.
REQ-023 In HUNT, a sampled bit with MK=1 SHALL be taken as bit 15 of word 0 of string 0, and the state SHALL go to LOCKED.
REQ-024 In LOCKED, each bit SHALL shift into a 16-bit register MSB first; bit count 15 down to 0, then word 0..19 and string 0..63, all wrapping.
REQ-025 After bit 0 of a word, in the following clk cycle:
- word_valid SHALL pulse;
- word_data, word_idx and str_idx SHALL update.
REQ-026 Latency SHALL be exactly 1 clk cycle from the falling-edge detection of bit 0 to word_valid.
REQ-027 Tag check, word 0: bit 0 SHALL be 0, otherwise err_tag pulses with that word_valid.
REQ-028 Tag check, word 10: bit 0 SHALL be 1, otherwise err_tag pulses with that word_valid.
REQ-029 A tag error SHALL NOT drop lock.
REQ-030 For word 0 of string 0, frm_num SHALL load word_data[15:7] in the same cycle as the frame_start pulse.
REQ-031 In LOCKED, MK=1 sampled anywhere other than bit 15/word 0/string 0 SHALL:
- pulse err_marker;
- realign so that bit is bit 15 of word 0 of string 0;
- discard the partial word;
- keep the state LOCKED.
REQ-032 In LOCKED, MK=0 at bit 15/word 0/string 0 SHALL be tolerated without error.
REQ-033 Timeout: TIMEOUT_CYC clk cycles with no CLK falling edge SHALL force HUNT, clear locked and discard the partial word.
REQ-034 The timeout SHALL NOT increment err_cnt.
REQ-035 err_cnt SHALL add 1 per cycle with err_marker or err_tag, and hold at its maximum value.
REQ-036 err_marker and err_tag SHALL never both pulse for the same bit.
REQ-037 locked SHALL be high exactly while the state is LOCKED.

Reset
REQ-038 While reset=1:
- state SHALL be HUNT;
- all synchronizer flops, counters and outputs SHALL be 0, including word_valid, frame_start, err_* and locked.
REQ-039 Reset asserted mid-word SHALL discard all partial data.
REQ-040 After reset release, the first word_valid SHALL follow only the next MK.

Structure
REQ-041 Package lomo_pkg SHALL hold:
- BITS_PER_WORD=16, WORDS_PER_STR=20, STR_PER_FRM=64;
- tag word indices 0 and 10;
- the state enum.
REQ-042 One sub-module, lomo_sync_edge, SHALL provide the 3-flop synchronizer plus falling-edge detect and be instantiated once per input.

Verification
REQ-043 Reset, then 2 clean frames (frm 5, 6; tags correct; CLK period 8 clk) -> frame_start twice, frm_num 5 then 6, 2560 word_valid, err_cnt 0.
REQ-044 Word 3 of string 2 = 16'hA5C3 -> word_valid with word_data A5C3, word_idx 3, str_idx 2.
REQ-045 Word 10 tag bit forced to 0 -> err_tag one pulse, err_cnt 1, locked stays 1.
REQ-046 MK injected at word 7 of string 4 -> err_marker pulse; that bit becomes word 0/string 0 and the next frame_start follows 20480 bits later.
REQ-047 CLK stopped for 4096 clk cycles -> locked 0 and no further word_valid until MK.
REQ-048 Reset pulse mid-word 12 -> all outputs 0, HUNT, and clean reacquisition on the next MK.

Source files
------------

// File: rtl/lomo_pkg.sv
// Shared constants and state type for the LOMO serial frame receiver.
package lomo_pkg;

  localparam int BITS_PER_WORD = 16;
  localparam int WORDS_PER_STR = 20;
  localparam int STR_PER_FRM   = 64;

  // Word 0 carries tag bit 0, word 10 carries tag bit 1.
  localparam int TAG_WORD_LO = 0;
  localparam int TAG_WORD_HI = 10;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } lomo_state_t;

endpackage

// File: rtl/lomo_sync_edge.sv
// Three-flop synchronizer for one asynchronous link input, with falling-edge detect.
module lomo_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q2,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], i_d};
  end

  assign o_q2   = r_sync[1];
  assign o_fall = !r_sync[1] && r_sync[2];

endmodule

// File: rtl/lomo_frame_receiver.sv
// Deserializes the LOMO link into 16-bit words and tracks word/string/frame position.
//   state     | meaning
//   ST_HUNT   | waiting for MK to mark bit 15 of word 0, string 0
//   ST_LOCKED | aligned; counting bits, words and strings
module lomo_frame_receiver
  import lomo_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MK,
  input  logic                 CLK,
  input  logic                 DAT,
  output logic [15:0]          word_data,
  output logic [4:0]           word_idx,
  output logic [5:0]           str_idx,
  output logic                 word_valid,
  output logic                 frame_start,
  output logic [8:0]           frm_num,
  output logic                 locked,
  output logic                 err_marker,
  output logic                 err_tag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  lomo_state_t r_state, w_state_nxt;

  logic w_clk_fall, w_clk_s2;
  logic w_dat_s2, w_dat_fall;
  logic w_mk_s2, w_mk_fall;
  logic w_unused;

  logic [14:0]          r_shift;
  logic [3:0]           r_bit_cnt;
  logic [4:0]           r_word_cnt;
  logic [5:0]           r_str_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [15:0]          r_word_data;
  logic [4:0]           r_word_idx;
  logic [5:0]           r_str_idx;
  logic [8:0]           r_frm_num;
  logic                 r_word_valid, r_frame_start, r_err_marker, r_err_tag;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_at_head, w_realign, w_mk_err, w_shift_bit, w_word_done;
  logic        w_tag_err, w_timeout, w_first_word;
  logic [15:0] w_word;

  lomo_sync_edge u_sync_clk (.clk(clk), .reset(reset), .i_d(CLK), .o_q2(w_clk_s2), .o_fall(w_clk_fall));
  lomo_sync_edge u_sync_dat (.clk(clk), .reset(reset), .i_d(DAT), .o_q2(w_dat_s2), .o_fall(w_dat_fall));
  lomo_sync_edge u_sync_mk  (.clk(clk), .reset(reset), .i_d(MK),  .o_q2(w_mk_s2),  .o_fall(w_mk_fall));

  assign w_unused = ^{w_clk_s2, w_dat_fall, w_mk_fall};

  assign w_at_head    = (r_bit_cnt == 4'(BITS_PER_WORD - 1)) && (r_word_cnt == '0) && (r_str_cnt == '0);
  assign w_first_word = (r_word_cnt == '0) && (r_str_cnt == '0);
  // Any MK off the frame head re-anchors the position; in HUNT it is the acquisition itself.
  assign w_realign    = w_clk_fall && w_mk_s2 && ((r_state == ST_HUNT) || !w_at_head);
  assign w_mk_err     = w_realign && (r_state == ST_LOCKED);
  assign w_shift_bit  = w_clk_fall && (r_state == ST_LOCKED) && !w_realign;
  assign w_word_done  = w_shift_bit && (r_bit_cnt == '0);
  assign w_word       = {r_shift, w_dat_s2};
  assign w_tag_err    = w_word_done &&
                        (((r_word_cnt == 5'(TAG_WORD_LO)) && w_dat_s2) ||
                         ((r_word_cnt == 5'(TAG_WORD_HI)) && !w_dat_s2));
  assign w_timeout    = (r_state == ST_LOCKED) && !w_clk_fall && (r_to_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT:   if (w_clk_fall && w_mk_s2) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_timeout)             w_state_nxt = ST_HUNT;
      default:                              w_state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    locked = 1'b0;
    case (r_state)
      ST_LOCKED: locked = 1'b1;
      default:   locked = 1'b0;
    endcase
  end

  // Down-counter reloaded on every bit; terminal count means the link clock stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_to_cnt <= '0;
    else if (w_clk_fall)     r_to_cnt <= TO_W'(TIMEOUT_CYC - 1);
    else if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_str_cnt     <= '0;
      r_word_data   <= '0;
      r_word_idx    <= '0;
      r_str_idx     <= '0;
      r_frm_num     <= '0;
      r_word_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_err_marker  <= 1'b0;
      r_err_tag     <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_word_valid  <= w_word_done;
      r_frame_start <= w_word_done && w_first_word;
      r_err_marker  <= w_mk_err;
      r_err_tag     <= w_tag_err;
      if ((w_mk_err || w_tag_err) && (r_err_cnt != {ERR_CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;

      if (w_timeout) begin
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_str_cnt  <= '0;
      end else if (w_realign) begin
        r_shift    <= {14'd0, w_dat_s2};
        r_bit_cnt  <= 4'(BITS_PER_WORD - 2);
        r_word_cnt <= '0;
        r_str_cnt  <= '0;
      end else if (w_shift_bit) begin
        r_shift <= w_word[14:0];
        if (r_bit_cnt == '0) begin
          r_bit_cnt   <= 4'(BITS_PER_WORD - 1);
          r_word_data <= w_word;
          r_word_idx  <= r_word_cnt;
          r_str_idx   <= r_str_cnt;
          if (w_first_word) r_frm_num <= w_word[15:7];
          if (r_word_cnt == 5'(WORDS_PER_STR - 1)) begin
            r_word_cnt <= '0;
            r_str_cnt  <= (r_str_cnt == 6'(STR_PER_FRM - 1)) ? '0 : r_str_cnt + 1'b1;
          end else begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt - 1'b1;
        end
      end
    end
  end

  assign word_data   = r_word_data;
  assign word_idx    = r_word_idx;
  assign str_idx     = r_str_idx;
  assign word_valid  = r_word_valid;
  assign frame_start = r_frame_start;
  assign frm_num     = r_frm_num;
  assign err_marker  = r_err_marker;
  assign err_tag     = r_err_tag;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_lomo_frame_receiver.sv
// Scoreboard bench for lomo_frame_receiver: stimulus queues expected words, a monitor checks them.
module tb_lomo_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        mk_in, bclk, dat_in;
  logic [15:0] word_data;
  logic [4:0]  word_idx;
  logic [5:0]  str_idx;
  logic        word_valid, frame_start, locked, err_marker, err_tag;
  logic [8:0]  frm_num;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  widx;
    logic [5:0]  sidx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   n_wv = 0, n_fs = 0, n_etag = 0, n_emk = 0;
  int   half = 1;
  int   wv_before;

  lomo_frame_receiver #(.TIMEOUT_CYC(4096), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .MK(mk_in), .CLK(bclk), .DAT(dat_in),
    .word_data(word_data), .word_idx(word_idx), .str_idx(str_idx),
    .word_valid(word_valid), .frame_start(frame_start), .frm_num(frm_num),
    .locked(locked), .err_marker(err_marker), .err_tag(err_tag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic tag_bad(input exp_t e);
    return ((e.widx == 5'd0) && e.data[0]) || ((e.widx == 5'd10) && !e.data[0]);
  endfunction

  // Hand-built frame content: word 0/string 0 carries the frame number, tags are correct.
  function automatic logic [15:0] gen_word(input logic [8:0] frm, input int s, input int w);
    logic [15:0] v;
    if (s == 0 && w == 0) return {frm, 7'h00};
    if (s == 2 && w == 3) return 16'hA5C3;
    v = {6'(s), 5'(w), 5'(s + w + 3)};
    if (w == 0)  v[0] = 1'b0;
    if (w == 10) v[0] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (err_marker)  n_emk++;
      if (err_tag)     n_etag++;
      if (frame_start) n_fs++;
      if (err_marker || err_tag) check("marker_tag_exclusive", 32'(err_marker & err_tag), 32'd0);
      if (word_valid) begin
        n_wv++;
        if (exp_q.size() == 0) begin
          check("unexpected_word_valid", 32'(word_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data",   32'(word_data),   32'(mon_e.data));
          check("word_idx",    32'(word_idx),    32'(mon_e.widx));
          check("str_idx",     32'(str_idx),     32'(mon_e.sidx));
          check("frame_start", 32'(frame_start), 32'(mon_e.widx == 5'd0 && mon_e.sidx == 6'd0));
          check("err_tag",     32'(err_tag),     32'(tag_bad(mon_e)));
          if (mon_e.widx == 5'd0 && mon_e.sidx == 6'd0)
            check("frm_num", 32'(frm_num), 32'(mon_e.data[15:7]));
        end
      end
    end
  end

  task automatic send_bit(input logic d, input logic m);
    dat_in = d;
    mk_in  = m;
    bclk   = 1'b1;
    repeat (half) @(negedge clk);
    bclk   = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_range(input logic [15:0] data, input int hi, input int lo, input logic mk_first);
    for (int i = hi; i >= lo; i--) send_bit(data[i], mk_first && (i == hi));
  endtask

  task automatic send_word(input logic [15:0] data, input logic mk_first, input logic expect_out,
                           input int w, input int s);
    exp_t e;
    if (expect_out) begin
      e.data = data;
      e.widx = 5'(w);
      e.sidx = 6'(s);
      exp_q.push_back(e);
    end
    send_range(data, 15, 0, mk_first);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_data"},   32'(word_data),   32'd0);
    check({tag, "_word_idx"},    32'(word_idx),    32'd0);
    check({tag, "_str_idx"},     32'(str_idx),     32'd0);
    check({tag, "_word_valid"},  32'(word_valid),  32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_frm_num"},     32'(frm_num),     32'd0);
    check({tag, "_locked"},      32'(locked),      32'd0);
    check({tag, "_err_marker"},  32'(err_marker),  32'd0);
    check({tag, "_err_tag"},     32'(err_tag),     32'd0);
    check({tag, "_err_cnt"},     32'(err_cnt),     32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    reset = 1'b1; bclk = 1'b0; mk_in = 1'b0; dat_in = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Two clean frames at a fast bit clock: frame 5 in full, then word 0 of frame 6.
    half = 1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 20; w++)
        send_word(gen_word(9'd5, s, w), (s == 0 && w == 0), 1'b1, w, s);
    send_word(gen_word(9'd6, 0, 0), 1'b1, 1'b1, 0, 0);
    drain();
    check("clean_frame_starts", 32'(n_fs),    32'd2);
    check("clean_word_valids",  32'(n_wv),    32'd1281);
    check("clean_frm_num",      32'(frm_num), 32'd6);
    check("clean_err_cnt",      32'(err_cnt), 32'd0);
    check("clean_locked",       32'(locked),  32'd1);
    check("clean_no_err_tag",   32'(n_etag),  32'd0);

    // CLK period of 8 clk from here: wrong tag on word 10, then a stray MK at word 7/string 4.
    half = 4;
    for (int w = 1; w < 20; w++) begin
      d = gen_word(9'd6, 0, w);
      if (w == 10) d[0] = 1'b0;
      send_word(d, 1'b0, 1'b1, w, 0);
    end
    drain();
    check("tag_err_pulses", 32'(n_etag),  32'd1);
    check("tag_err_cnt",    32'(err_cnt), 32'd1);
    check("tag_err_locked", 32'(locked),  32'd1);
    for (int s = 1; s < 4; s++)
      for (int w = 0; w < 20; w++)
        send_word(gen_word(9'd6, s, w), 1'b0, 1'b1, w, s);
    for (int w = 0; w < 7; w++) send_word(gen_word(9'd6, 4, w), 1'b0, 1'b1, w, 4);
    send_word(16'h0380, 1'b1, 1'b1, 0, 0);
    send_word(gen_word(9'd7, 0, 1), 1'b0, 1'b1, 1, 0);
    send_word(gen_word(9'd7, 0, 2), 1'b0, 1'b1, 2, 0);
    drain();
    check("mk_err_pulses", 32'(n_emk),   32'd1);
    check("mk_err_cnt",    32'(err_cnt), 32'd2);
    check("mk_frame_start",32'(n_fs),    32'd3);
    check("mk_frm_num",    32'(frm_num), 32'd7);
    check("mk_locked",     32'(locked),  32'd1);

    // Stop the bit clock mid-word.
    send_range(gen_word(9'd7, 0, 3), 15, 11, 1'b0);
    repeat (4000) @(negedge clk);
    check("timeout_not_yet", 32'(locked), 32'd1);
    repeat (150) @(negedge clk);
    check("timeout_unlocked", 32'(locked),  32'd0);
    check("timeout_err_cnt",  32'(err_cnt), 32'd2);
    wv_before = n_wv;
    send_word(16'hFFFF, 1'b0, 1'b0, 0, 0);
    send_word(16'h1234, 1'b0, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    check("hunt_no_words", 32'(n_wv), 32'(wv_before));
    send_word(16'h0500, 1'b1, 1'b1, 0, 0);
    send_word(gen_word(9'd10, 0, 1), 1'b0, 1'b1, 1, 0);
    drain();
    check("relock_locked",  32'(locked),  32'd1);
    check("relock_frm_num", 32'(frm_num), 32'd10);

    // Reset pulse in the middle of word 12.
    for (int w = 2; w < 12; w++) send_word(gen_word(9'd10, 0, w), 1'b0, 1'b1, w, 0);
    drain();
    send_range(gen_word(9'd10, 0, 12), 15, 9, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    @(negedge clk);
    wv_before = n_wv;
    send_range(gen_word(9'd10, 0, 12), 8, 0, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    check("post_reset_no_words", 32'(n_wv), 32'(wv_before));
    send_word(16'h0600, 1'b1, 1'b1, 0, 0);
    send_word(gen_word(9'd12, 0, 1), 1'b0, 1'b1, 1, 0);
    drain();
    check("reacq_locked",  32'(locked),  32'd1);
    check("reacq_frm_num", 32'(frm_num), 32'd12);
    check("reacq_err_cnt", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
